// File: rtl/seg_pkg.sv
// Shared glyph constants, FSM state type and decoded-digit type for the 7-segment reader.
// Hex glyph constants are only consulted when SEG_READER_HEX_EN is defined.
package seg_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  localparam logic [1:0] DISP_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } state_e;

  typedef struct packed {
    logic       blank;
    logic [3:0] value;
  } digit_t;

  localparam digit_t DIGIT_RESET = '{blank: 1'b1, value: 4'd0};

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational active-low glyph to BCD decoder; blank decodes to value 0 with blank set.
// Defining SEG_READER_HEX_EN makes glyphs A-F legal (values 10-15).
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       legal_o,
  output digit_t     digit_o
);

  always_comb begin
    legal_o = 1'b1;
    digit_o = '{blank: 1'b0, value: 4'd0};
    case (seg_i)
      GLYPH_0:     digit_o.value = 4'd0;
      GLYPH_1:     digit_o.value = 4'd1;
      GLYPH_2:     digit_o.value = 4'd2;
      GLYPH_3:     digit_o.value = 4'd3;
      GLYPH_4:     digit_o.value = 4'd4;
      GLYPH_5:     digit_o.value = 4'd5;
      GLYPH_6:     digit_o.value = 4'd6;
      GLYPH_7:     digit_o.value = 4'd7;
      GLYPH_8:     digit_o.value = 4'd8;
      GLYPH_9:     digit_o.value = 4'd9;
      GLYPH_BLANK: digit_o.blank = 1'b1;
`ifdef SEG_READER_HEX_EN
      GLYPH_A:     digit_o.value = 4'd10;
      GLYPH_B:     digit_o.value = 4'd11;
      GLYPH_C:     digit_o.value = 4'd12;
      GLYPH_D:     digit_o.value = 4'd13;
      GLYPH_E:     digit_o.value = 4'd14;
      GLYPH_F:     digit_o.value = 4'd15;
`endif
      default:     legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_display_reader.sv
// Reads back two digits from a multiplexed active-low 7-segment bus and publishes them as a pair.
// Hex glyph acceptance is enabled by defining SEG_READER_HEX_EN (see seg_glyph_decode).
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no single digit enabled (11 or illegal overlap 00)
// ST_SETTLE | counting consecutive identical samples of one window
// ST_HELD   | window accepted once; waiting for the bus to change
module seg_display_reader
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] display_i,
  input  logic [6:0] seg_i,
  output logic [3:0] digit0_o,
  output logic [3:0] digit1_o,
  output logic       blank0_o,
  output logic       blank1_o,
  output logic       valid_o,
  output logic       err_o
);

  localparam logic [7:0] CNT_ACCEPT = 8'(STABLE_CYCLES);

  logic [1:0] disp_q, prev_disp_q;
  logic [6:0] seg_q, prev_seg_q;
  state_e     state_q;
  logic [7:0] cnt_q;
  digit_t     shadow0_q, shadow1_q;
  logic       cap0_q, cap1_q;
  logic       valid_q, err_q;
  digit_t     out0_q, out1_q;

  logic       win;
  logic       same;
  logic       glyph_legal;
  digit_t     glyph;

  seg_glyph_decode u_decode (
    .seg_i   (seg_q),
    .legal_o (glyph_legal),
    .digit_o (glyph)
  );

  assign win  = (disp_q == 2'b10) || (disp_q == 2'b01);
  assign same = ({disp_q, seg_q} == {prev_disp_q, prev_seg_q});

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      disp_q      <= DISP_NONE;
      seg_q       <= GLYPH_BLANK;
      prev_disp_q <= DISP_NONE;
      prev_seg_q  <= GLYPH_BLANK;
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      shadow0_q   <= DIGIT_RESET;
      shadow1_q   <= DIGIT_RESET;
      cap0_q      <= 1'b0;
      cap1_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      out0_q      <= DIGIT_RESET;
      out1_q      <= DIGIT_RESET;
    end else begin
      disp_q      <= display_i;
      seg_q       <= seg_i;
      prev_disp_q <= disp_q;
      prev_seg_q  <= seg_q;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;

      // Publish first; an acceptance on the same edge below re-sets its flag.
      if (cap0_q && cap1_q) begin
        out0_q  <= shadow0_q;
        out1_q  <= shadow1_q;
        valid_q <= 1'b1;
        cap0_q  <= 1'b0;
        cap1_q  <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (win) begin
            state_q <= ST_SETTLE;
            cnt_q   <= 8'd1;
          end
        end
        ST_SETTLE: begin
          if (!win) begin
            state_q <= ST_IDLE;
          end else if (!same) begin
            cnt_q <= 8'd1;
          end else if (cnt_q + 8'd1 >= CNT_ACCEPT) begin
            cnt_q   <= CNT_ACCEPT;
            state_q <= ST_HELD;
            if (!glyph_legal) begin
              err_q <= 1'b1;
            end else if (!disp_q[0]) begin
              shadow0_q <= glyph;
              cap0_q    <= 1'b1;
            end else begin
              shadow1_q <= glyph;
              cap1_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_HELD: begin
          if (!win) begin
            state_q <= ST_IDLE;
          end else if (!same) begin
            state_q <= ST_SETTLE;
            cnt_q   <= 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign digit0_o = out0_q.value;
  assign digit1_o = out1_q.value;
  assign blank0_o = out0_q.blank;
  assign blank1_o = out1_q.blank;
  assign valid_o  = valid_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_seg_display_reader.sv
// Directed bench for seg_display_reader: expected publishes are queued at stimulus time and
// popped when valid pulses; err pulses are counted against an expected total.
module tb_seg_display_reader;

  typedef struct packed {
    logic [3:0] d0;
    logic [3:0] d1;
    logic       b0;
    logic       b1;
  } pub_t;

  logic       clk;
  logic       reset;
  logic [1:0] display;
  logic [6:0] seg;
  logic [3:0] digit0, digit1;
  logic       blank0, blank1, valid, err;

  int   total;
  int   passed;
  int   err_seen;
  int   err_exp;
  logic valid_prev;
  logic err_prev;
  pub_t exp_q[$];

  seg_display_reader #(.STABLE_CYCLES(4)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .display_i (display),
    .seg_i     (seg),
    .digit0_o  (digit0),
    .digit1_o  (digit1),
    .blank0_o  (blank0),
    .blank1_o  (blank1),
    .valid_o   (valid),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [1:0] d, input logic [6:0] s, input int n);
    display = d;
    seg     = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pub(input logic [3:0] d0, input logic [3:0] d1,
                            input logic b0, input logic b1);
    pub_t p;
    p = '{d0: d0, d1: d1, b0: b0, b1: b1};
    exp_q.push_back(p);
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                               input logic b0, input logic b1);
    check({tag, "_digit0"}, 32'(digit0), 32'(d0));
    check({tag, "_digit1"}, 32'(digit1), 32'(d1));
    check({tag, "_blank0"}, 32'(blank0), 32'(b0));
    check({tag, "_blank1"}, 32'(blank1), 32'(b1));
  endtask

  task automatic check_done(input string tag);
    check({tag, "_pending_pubs"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_err_count"}, 32'(err_seen), 32'(err_exp));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      valid_prev <= 1'b0;
      err_prev   <= 1'b0;
    end else begin
      if (valid) begin
        check("valid_width", 32'(valid_prev), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(valid), 32'd0);
        end else begin
          pub_t e;
          e = exp_q.pop_front();
          check("pub_digit0", 32'(digit0), 32'(e.d0));
          check("pub_digit1", 32'(digit1), 32'(e.d1));
          check("pub_blank0", 32'(blank0), 32'(e.b0));
          check("pub_blank1", 32'(blank1), 32'(e.b1));
        end
      end
      if (err) begin
        check("err_width", 32'(err_prev), 32'd0);
        err_seen++;
      end
      valid_prev <= valid;
      err_prev   <= err;
    end
  end

  initial begin
    total    = 0;
    passed   = 0;
    err_seen = 0;
    err_exp  = 0;
    reset    = 1'b1;
    display  = 2'b11;
    seg      = 7'h7F;
    repeat (3) @(negedge clk);
    check_outputs("reset", 4'd0, 4'd0, 1'b1, 1'b1);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    reset = 1'b0;

    // Basic pair: units 3, tens 7
    expect_pub(4'd3, 4'd7, 1'b0, 1'b0);
    hold(2'b10, 7'h30, 6);
    hold(2'b11, 7'h7F, 2);
    hold(2'b01, 7'h78, 6);
    hold(2'b11, 7'h7F, 6);
    check_done("basic");
    check_outputs("basic", 4'd3, 4'd7, 1'b0, 1'b0);

    // Glitch rejection: 3-cycle 0 glyph must not be taken
    expect_pub(4'd1, 4'd0, 1'b0, 1'b0);
    hold(2'b10, 7'h40, 3);
    hold(2'b10, 7'h79, 5);
    hold(2'b01, 7'h40, 5);
    hold(2'b11, 7'h7F, 6);
    check_done("glitch");
    check_outputs("glitch", 4'd1, 4'd0, 1'b0, 1'b0);

    // Illegal glyph held long: exactly one err, no publish
    err_exp++;
    hold(2'b10, 7'h55, 20);
    hold(2'b11, 7'h7F, 4);
    check_done("illegal");
    check_outputs("illegal", 4'd1, 4'd0, 1'b0, 1'b0);

    // Overlap gives nothing; then tens blank + units 5
    hold(2'b00, 7'h00, 10);
    hold(2'b11, 7'h7F, 2);
    check_done("overlap");
    expect_pub(4'd5, 4'd0, 1'b0, 1'b1);
    hold(2'b01, 7'h7F, 6);
    hold(2'b10, 7'h12, 6);
    hold(2'b11, 7'h7F, 6);
    check_done("blank");
    check_outputs("blank", 4'd5, 4'd0, 1'b0, 1'b1);

    // Reset after units capture discards it
    hold(2'b10, 7'h10, 6);
    reset = 1'b1;
    display = 2'b11;
    seg = 7'h7F;
    @(negedge clk);
    reset = 1'b0;
    check_outputs("midreset", 4'd0, 4'd0, 1'b1, 1'b1);
    hold(2'b01, 7'h19, 6);
    hold(2'b11, 7'h7F, 8);
    check_done("midreset_tens_only");
    expect_pub(4'd0, 4'd4, 1'b0, 1'b0);
    hold(2'b10, 7'h40, 6);
    hold(2'b11, 7'h7F, 6);
    check_done("midreset_units");
    check_outputs("midreset_pub", 4'd0, 4'd4, 1'b0, 1'b0);

    // Hex glyphs A and E
`ifdef SEG_READER_HEX_EN
    expect_pub(4'd10, 4'd14, 1'b0, 1'b0);
`else
    err_exp += 2;
`endif
    hold(2'b10, 7'h08, 6);
    hold(2'b01, 7'h0E, 6);
    hold(2'b11, 7'h7F, 6);
    check_done("hex");
`ifdef SEG_READER_HEX_EN
    check_outputs("hex", 4'd10, 4'd14, 1'b0, 1'b0);
`else
    check_outputs("hex", 4'd0, 4'd4, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
